obstacle_scroller: RTL and testbench



---
 rtl/flappy_pkg.sv | 47 ++++
 rtl/obstacle_scroller_if.sv | 42 ++++
 rtl/obstacle_scroller_lane.sv | 63 ++++++
 rtl/obstacle_scroller.sv | 159 +++++++++++++++
 tb/tb_obstacle_scroller.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flappy_pkg.sv
// ---------------------------------------------------------------------------
// flappy_pkg
// Shared constants for the Flappy obstacle generator: screen and pipe
// geometry, run/halt state encodings, the LFSR seed and step function, and
// the tables of starting X/Y edges for the four pipe lanes.
// ---------------------------------------------------------------------------
package flappy_pkg;

    localparam int SCREEN_W     = 640;
    localparam int PIPE_W       = 80;
    localparam int PIPE_SPACING = 160;
    localparam int NUM_LANES    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Fibonacci LFSR, taps 16/14/13/11 (bits 15, 13, 12, 10), shifting left.
    function automatic logic [15:0] lfsr_next(input logic [15:0] value);
        return {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
    endfunction

    // Starting left edge of each lane, one pipe spacing apart.
    function automatic logic [9:0] init_x(input int lane);
        case (lane)
            0:       return 10'd320;
            1:       return 10'd480;
            2:       return 10'd0;
            default: return 10'd160;
        endcase
    endfunction

    // Starting gap-top edge of each lane.
    function automatic logic [9:0] init_y(input int lane);
        case (lane)
            0:       return 10'd140;
            1:       return 10'd200;
            2:       return 10'd260;
            default: return 10'd320;
        endcase
    endfunction

endpackage

// File: rtl/obstacle_scroller_if.sv
// ---------------------------------------------------------------------------
// obstacle_scroller_if
// Bundles the game-controller pulses and the obstacle outputs consumed by
// the VGA stage.
//   start, crash        : one-cycle pulses from the game controller
//   X_Edge_O1..O4       : pipe left edges (0..639)
//   Y_Edge_O1..O4       : gap-top edges
//   score, pass_pulse   : pipes passed and a one-cycle pass strobe
//   state               : IDLE=0, RUN=1, HALT=2
// slave is the obstacle generator side, master the controller/consumer side.
// ---------------------------------------------------------------------------
interface obstacle_scroller_if;

    logic       start;
    logic       crash;
    logic [9:0] X_Edge_O1;
    logic [9:0] X_Edge_O2;
    logic [9:0] X_Edge_O3;
    logic [9:0] X_Edge_O4;
    logic [9:0] Y_Edge_O1;
    logic [9:0] Y_Edge_O2;
    logic [9:0] Y_Edge_O3;
    logic [9:0] Y_Edge_O4;
    logic [7:0] score;
    logic       pass_pulse;
    logic [1:0] state;

    modport slave (
        input  start, crash,
        output X_Edge_O1, X_Edge_O2, X_Edge_O3, X_Edge_O4,
        output Y_Edge_O1, Y_Edge_O2, Y_Edge_O3, Y_Edge_O4,
        output score, pass_pulse, state
    );

    modport master (
        output start, crash,
        input  X_Edge_O1, X_Edge_O2, X_Edge_O3, X_Edge_O4,
        input  Y_Edge_O1, Y_Edge_O2, Y_Edge_O3, Y_Edge_O4,
        input  score, pass_pulse, state
    );

endinterface

// File: rtl/obstacle_scroller_lane.sv
// ---------------------------------------------------------------------------
// obstacle_lane
// One pipe lane: holds the X/Y edge registers, moves the pipe left on each
// tick, wraps it to the right edge of the screen with a fresh gap height,
// and flags when this tick's move carries the pipe's right edge past the
// bird column.
//   clk, reset   : clock and synchronous active-low reset
//   reinit       : reload the starting X/Y for this lane
//   tick         : scroll step strobe
//   rnd          : 8 random bits used for the new gap height on wrap
//   x, y         : registered pipe left edge and gap-top edge
//   pass         : this tick's move would pass the bird (combinational)
// ---------------------------------------------------------------------------
module obstacle_lane
    import flappy_pkg::*;
#(
    parameter int LANE    = 0,
    parameter int SPEED   = 2,
    parameter int BIRD_X  = 160,
    parameter int GAP_MIN = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       reinit,
    input  logic       tick,
    input  logic [7:0] rnd,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       pass
);

    localparam logic [9:0] SPEED_V  = 10'(SPEED);
    localparam logic [9:0] BIRD_V   = 10'(BIRD_X);
    localparam logic [9:0] GAP_V    = 10'(GAP_MIN);
    localparam logic [9:0] PIPE_V   = 10'(PIPE_W);
    localparam logic [9:0] SCREEN_V = 10'(SCREEN_W);

    logic       wrap;
    logic [9:0] x_move;

    // Next position; a wrapped pipe re-enters from the right, and a wrap is
    // never counted as a pass even though its right edge jumps.
    always_comb begin
        wrap   = (x < SPEED_V);
        x_move = wrap ? (x + SCREEN_V - SPEED_V) : (x - SPEED_V);
        pass   = !wrap && ((x + PIPE_V) >= BIRD_V) && ((x_move + PIPE_V) < BIRD_V);
    end

    // Edge registers only move on a tick, so they hold whenever the
    // scroller is not running.
    always_ff @(posedge clk) begin
        if (!reset || reinit) begin
            x <= init_x(LANE);
            y <= init_y(LANE);
        end else if (tick) begin
            x <= x_move;
            if (wrap) begin
                y <= GAP_V + {2'b00, rnd};
            end
        end
    end

endmodule

// File: rtl/obstacle_scroller.sv
// ---------------------------------------------------------------------------
// obstacle_scroller
// Generates the four scrolling pipe obstacles and the pass score for Flappy.
// Holds the IDLE/RUN/HALT state machine, the scroll-step tick divider, the
// gap-height LFSR and the saturating score adder; the per-pipe motion lives
// in four obstacle_lane instances.
//   clk   : pixel clock
//   reset : synchronous, active-low
//   bus   : obstacle_scroller_if.slave (start/crash in; edges, score,
//           pass_pulse and state out)
// ---------------------------------------------------------------------------
module obstacle_scroller
    import flappy_pkg::*;
#(
    parameter int TICK_DIV = 416667,
    parameter int SPEED    = 2,
    parameter int BIRD_X   = 160,
    parameter int GAP_MIN  = 100
) (
    input  logic                  clk,
    input  logic                  reset,
    obstacle_scroller_if.slave    bus
);

    localparam int               CNT_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    state_t            cur_state;
    state_t            next_state;
    logic              enter_run;
    logic              reinit;
    logic              tick;
    logic [CNT_W-1:0]  tick_cnt;
    logic [15:0]       lfsr;
    logic [7:0]        score_q;
    logic              pulse_q;
    logic [2:0]        pass_count;
    logic [8:0]        score_sum;

    logic [9:0]        lane_x    [NUM_LANES];
    logic [9:0]        lane_y    [NUM_LANES];
    logic              lane_pass [NUM_LANES];

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // Next-state logic. Crash takes priority over start while running, and a
    // restart from HALT reloads the playfield on the same edge it resumes.
    always_comb begin
        next_state = cur_state;
        enter_run  = 1'b0;
        reinit     = 1'b0;
        case (cur_state)
            IDLE: begin
                if (bus.start) begin
                    next_state = RUN;
                    enter_run  = 1'b1;
                end
            end
            RUN: begin
                if (bus.crash) begin
                    next_state = HALT;
                end
            end
            HALT: begin
                if (bus.start) begin
                    next_state = RUN;
                    enter_run  = 1'b1;
                    reinit     = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign tick = (cur_state == RUN) && (tick_cnt == TICK_LAST);

    // Scroll-step divider, restarted from zero every time RUN is entered.
    always_ff @(posedge clk) begin
        if (!reset || enter_run) begin
            tick_cnt <= '0;
        end else if (cur_state == RUN) begin
            tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
        end
    end

    // Gap-height LFSR; free-runs while playing and survives a restart so
    // successive games see different gaps.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr <= LFSR_SEED;
        end else if (cur_state == RUN) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_LANES; k++) begin : g_lane
            obstacle_lane #(
                .LANE    (k),
                .SPEED   (SPEED),
                .BIRD_X  (BIRD_X),
                .GAP_MIN (GAP_MIN)
            ) u_lane (
                .clk    (clk),
                .reset  (reset),
                .reinit (reinit),
                .tick   (tick),
                .rnd    (lfsr[2*k +: 8]),
                .x      (lane_x[k]),
                .y      (lane_y[k]),
                .pass   (lane_pass[k])
            );
        end
    endgenerate

    // Number of lanes crossing the bird this step, added with saturation.
    always_comb begin
        pass_count = {2'b00, lane_pass[0]} + {2'b00, lane_pass[1]}
                   + {2'b00, lane_pass[2]} + {2'b00, lane_pass[3]};
        score_sum  = {1'b0, score_q} + {6'b000000, pass_count};
    end

    // Score and pass strobe; the strobe is registered so it lands in the
    // cycle after the tick, alongside the updated edges.
    always_ff @(posedge clk) begin
        if (!reset || reinit) begin
            score_q <= 8'd0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= tick && (pass_count != 3'd0);
            if (tick) begin
                score_q <= score_sum[8] ? 8'hFF : score_sum[7:0];
            end
        end
    end

    assign bus.X_Edge_O1  = lane_x[0];
    assign bus.X_Edge_O2  = lane_x[1];
    assign bus.X_Edge_O3  = lane_x[2];
    assign bus.X_Edge_O4  = lane_x[3];
    assign bus.Y_Edge_O1  = lane_y[0];
    assign bus.Y_Edge_O2  = lane_y[1];
    assign bus.Y_Edge_O3  = lane_y[2];
    assign bus.Y_Edge_O4  = lane_y[3];
    assign bus.score      = score_q;
    assign bus.pass_pulse = pulse_q;
    assign bus.state      = cur_state;

endmodule

// File: tb/tb_obstacle_scroller.sv
// ---------------------------------------------------------------------------
// tb_obstacle_scroller
// Self-checking bench for obstacle_scroller with TICK_DIV=4, SPEED=2.
// A cycle-level reference model of the pipe scroller produces the expected
// output snapshot for every driven cycle; snapshots are queued when the
// stimulus is applied and popped and compared after the clock edge. Directed
// checks against fixed values cover the reset state, first step, passes,
// crash/restart, simultaneous start+crash and reset mid-run.
// ---------------------------------------------------------------------------
module tb_obstacle_scroller;

    localparam int TICK_DIV = 4;
    localparam int SPEED    = 2;
    localparam int BIRD_X   = 160;
    localparam int GAP_MIN  = 100;

    typedef struct packed {
        logic [3:0][9:0] x;
        logic [3:0][9:0] y;
        logic [7:0]      score;
        logic            pulse;
        logic [1:0]      st;
    } snap_t;

    logic clk;
    logic reset;

    obstacle_scroller_if bus ();

    obstacle_scroller #(
        .TICK_DIV (TICK_DIV),
        .SPEED    (SPEED),
        .BIRD_X   (BIRD_X),
        .GAP_MIN  (GAP_MIN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    check_count = 0;
    int    fail_count  = 0;
    snap_t exp_q [$];

    int          m_state;
    int          m_cnt;
    int          m_score;
    int          m_ticks;
    logic        m_pulse;
    logic [15:0] m_lfsr;
    int          m_x [4];
    int          m_y [4];

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [15:0] ref_lfsr_step(input logic [15:0] v);
        logic fb;
        fb = v[15] ^ v[13] ^ v[12] ^ v[10];
        return {v[14:0], fb};
    endfunction

    function automatic int rst_x(input int k);
        case (k)
            0: return 320;
            1: return 480;
            2: return 0;
            default: return 160;
        endcase
    endfunction

    function automatic int rst_y(input int k);
        return 140 + 60 * k;
    endfunction

    task automatic model_lanes_init();
        for (int k = 0; k < 4; k++) begin
            m_x[k] = rst_x(k);
            m_y[k] = rst_y(k);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 0;
        m_score = 0;
        m_ticks = 0;
        m_pulse = 1'b0;
        m_lfsr  = 16'hACE1;
        model_lanes_init();
    endtask

    // Advance the reference model by one clock edge for the given inputs.
    task automatic model_step(input logic s, input logic c, input logic r);
        logic        tick;
        logic [15:0] cur;
        int          passes;
        int          xn;
        if (!r) begin
            model_reset();
            return;
        end
        cur  = m_lfsr;
        tick = (m_state == 1) && (m_cnt == TICK_DIV - 1);
        if (m_state == 2 && s) begin
            model_lanes_init();
            m_score = 0;
            m_pulse = 1'b0;
            m_cnt   = 0;
            m_ticks = 0;
            m_state = 1;
            return;
        end
        passes = 0;
        if (tick) begin
            m_ticks++;
            for (int k = 0; k < 4; k++) begin
                if (m_x[k] >= SPEED) begin
                    xn = m_x[k] - SPEED;
                    if ((m_x[k] + 80 >= BIRD_X) && (xn + 80 < BIRD_X)) passes++;
                    m_x[k] = xn;
                end else begin
                    m_x[k] = m_x[k] + 640 - SPEED;
                    m_y[k] = GAP_MIN + int'(cur[2*k +: 8]);
                end
            end
            m_score = (m_score + passes > 255) ? 255 : m_score + passes;
        end
        m_pulse = tick && (passes > 0);
        if (m_state == 1) begin
            m_lfsr = ref_lfsr_step(m_lfsr);
            m_cnt  = tick ? 0 : m_cnt + 1;
            if (c) m_state = 2;
        end else if (m_state == 0 && s) begin
            m_state = 1;
            m_cnt   = 0;
        end
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        for (int k = 0; k < 4; k++) begin
            s.x[k] = 10'(m_x[k]);
            s.y[k] = 10'(m_y[k]);
        end
        s.score = 8'(m_score);
        s.pulse = m_pulse;
        s.st    = 2'(m_state);
        return s;
    endfunction

    function automatic snap_t dut_snap();
        snap_t s;
        s.x[0]  = bus.X_Edge_O1;
        s.x[1]  = bus.X_Edge_O2;
        s.x[2]  = bus.X_Edge_O3;
        s.x[3]  = bus.X_Edge_O4;
        s.y[0]  = bus.Y_Edge_O1;
        s.y[1]  = bus.Y_Edge_O2;
        s.y[2]  = bus.Y_Edge_O3;
        s.y[3]  = bus.Y_Edge_O4;
        s.score = bus.score;
        s.pulse = bus.pass_pulse;
        s.st    = bus.state;
        return s;
    endfunction

    task automatic compare_snapshot();
        snap_t e;
        snap_t o;
        if (exp_q.size() == 0) begin
            check_output("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        o = dut_snap();
        for (int k = 0; k < 4; k++) begin
            check_output($sformatf("sb_x%0d", k + 1), 32'(o.x[k]), 32'(e.x[k]));
            check_output($sformatf("sb_y%0d", k + 1), 32'(o.y[k]), 32'(e.y[k]));
        end
        check_output("sb_score", 32'(o.score), 32'(e.score));
        check_output("sb_pulse", 32'(o.pulse), 32'(e.pulse));
        check_output("sb_state", 32'(o.st), 32'(e.st));
    endtask

    // Drive one cycle of inputs away from the edge, queue the expected
    // result, then sample the DUT just after the rising edge.
    task automatic apply_stimulus(input logic s, input logic c, input logic r);
        @(negedge clk);
        bus.start = s;
        bus.crash = c;
        reset     = r;
        model_step(s, c, r);
        exp_q.push_back(model_snap());
        @(posedge clk);
        #1;
        compare_snapshot();
    endtask

    task automatic run_until_tick(input int n, input int bound);
        int guard = 0;
        while (m_ticks < n && guard < bound) begin
            apply_stimulus(1'b0, 1'b0, 1'b1);
            guard++;
        end
        check_output("tick_reached", 32'(m_ticks), 32'(n));
    endtask

    task automatic check_reset_values(input string tag, input int st);
        check_output({tag, "_x1"}, 32'(bus.X_Edge_O1), 32'd320);
        check_output({tag, "_x2"}, 32'(bus.X_Edge_O2), 32'd480);
        check_output({tag, "_x3"}, 32'(bus.X_Edge_O3), 32'd0);
        check_output({tag, "_x4"}, 32'(bus.X_Edge_O4), 32'd160);
        check_output({tag, "_y1"}, 32'(bus.Y_Edge_O1), 32'd140);
        check_output({tag, "_y2"}, 32'(bus.Y_Edge_O2), 32'd200);
        check_output({tag, "_y3"}, 32'(bus.Y_Edge_O3), 32'd260);
        check_output({tag, "_y4"}, 32'(bus.Y_Edge_O4), 32'd320);
        check_output({tag, "_score"}, 32'(bus.score), 32'd0);
        check_output({tag, "_pulse"}, 32'(bus.pass_pulse), 32'd0);
        check_output({tag, "_state"}, 32'(bus.state), 32'(st));
    endtask

    initial begin
        logic [15:0] ref_lfsr;
        logic [9:0]  frozen_x1;
        logic [9:0]  frozen_x4;
        bus.start = 1'b0;
        bus.crash = 1'b0;
        reset     = 1'b0;

        $display("[TB] reset");
        apply_stimulus(1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_reset_values("rst", 0);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        check_output("idle_hold_state", 32'(bus.state), 32'd0);

        $display("[TB] start and first step");
        apply_stimulus(1'b1, 1'b0, 1'b1);
        check_output("start_state", 32'(bus.state), 32'd1);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 1'b1);
        check_output("pre_tick_x1", 32'(bus.X_Edge_O1), 32'd320);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        ref_lfsr = 16'hACE1;
        for (int i = 0; i < 3; i++) ref_lfsr = ref_lfsr_step(ref_lfsr);
        check_output("step1_x1", 32'(bus.X_Edge_O1), 32'd318);
        check_output("step1_x2", 32'(bus.X_Edge_O2), 32'd478);
        check_output("step1_x3", 32'(bus.X_Edge_O3), 32'd638);
        check_output("step1_x4", 32'(bus.X_Edge_O4), 32'd158);
        check_output("step1_y3", 32'(bus.Y_Edge_O3), 32'(GAP_MIN) + 32'(ref_lfsr[11:4]));
        check_output("step1_y1", 32'(bus.Y_Edge_O1), 32'd140);
        check_output("step1_y4", 32'(bus.Y_Edge_O4), 32'd320);

        $display("[TB] first pass");
        run_until_tick(40, 400);
        check_output("tick40_x4", 32'(bus.X_Edge_O4), 32'd80);
        check_output("tick40_score", 32'(bus.score), 32'd0);
        run_until_tick(41, 20);
        check_output("tick41_x4", 32'(bus.X_Edge_O4), 32'd78);
        check_output("tick41_score", 32'(bus.score), 32'd1);
        check_output("tick41_pulse", 32'(bus.pass_pulse), 32'd1);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        check_output("tick41_pulse_end", 32'(bus.pass_pulse), 32'd0);
        run_until_tick(121, 400);
        check_output("tick121_x1", 32'(bus.X_Edge_O1), 32'd78);
        check_output("tick121_score", 32'(bus.score), 32'd2);

        $display("[TB] crash and restart");
        apply_stimulus(1'b0, 1'b1, 1'b1);
        check_output("crash_state", 32'(bus.state), 32'd2);
        frozen_x1 = 10'(m_x[0]);
        frozen_x4 = 10'(m_x[3]);
        for (int i = 0; i < 50; i++) apply_stimulus(1'b0, 1'b0, 1'b1);
        check_output("halt_x1", 32'(bus.X_Edge_O1), 32'(frozen_x1));
        check_output("halt_x4", 32'(bus.X_Edge_O4), 32'(frozen_x4));
        check_output("halt_score", 32'(bus.score), 32'd2);
        apply_stimulus(1'b1, 1'b0, 1'b1);
        check_reset_values("restart", 1);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 1'b1);
        check_output("restart_pre_x1", 32'(bus.X_Edge_O1), 32'd320);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        check_output("restart_step_x1", 32'(bus.X_Edge_O1), 32'd318);

        $display("[TB] simultaneous start and crash");
        apply_stimulus(1'b1, 1'b1, 1'b1);
        check_output("simul_state", 32'(bus.state), 32'd2);
        check_output("simul_noreinit", 32'(bus.X_Edge_O1 == 10'd320), 32'd0);

        $display("[TB] reset mid-run");
        apply_stimulus(1'b1, 1'b0, 1'b1);
        check_output("rerun_state", 32'(bus.state), 32'd1);
        run_until_tick(201, 900);
        check_output("tick201_score", 32'(bus.score), 32'd3);
        check_output("tick201_x2", 32'(bus.X_Edge_O2), 32'd78);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_reset_values("midrst", 0);
        apply_stimulus(1'b1, 1'b0, 1'b1);
        check_output("after_rst_start", 32'(bus.state), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
